// File: rtl/writeback_unit.sv
// Writeback stage: commits decoder results to a 16x32 register file and steers the PC.
// A taken jump loads the PC and then squashes the next FLUSH_CYCLES in-flight results.
module writeback_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter bit          R0_ZERO      = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       outval,
   input  logic [5:0]        outreg,
   output logic [15:0][31:0] regarray,
   output logic [31:0]       pc,
   output logic              pc_load,
   output logic              flush,
   output logic [31:0]       retire_count
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 16;
   localparam int unsigned CNT_W = 3;

   typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt_nxt;
   logic [NREG-1:0][XLEN-1:0]  r_regs;
   logic [NREG-1:0][XLEN-1:0]  w_regs_nxt;
   logic [XLEN-1:0]            r_pc;
   logic [XLEN-1:0]            w_pc_nxt;
   logic                       r_pc_load;
   logic                       w_pc_load_nxt;
   logic                       r_flush;
   logic                       w_flush_nxt;
   logic [XLEN-1:0]            r_retire;
   logic [XLEN-1:0]            w_retire_nxt;
   logic                       w_xfer;
   logic                       w_jmp;
   logic                       w_wr_en;

   // The stage never stalls; it only refuses results while held in reset.
   assign in_ready = rst_n;
   assign w_xfer   = in_valid & rst_n;
   assign w_jmp    = outreg[5];
   assign w_wr_en  = ~outreg[4] & ~(R0_ZERO & (outreg[3:0] == 4'd0));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_RUN;
         r_cnt     <= '0;
         r_regs    <= '0;
         r_pc      <= RESET_PC;
         r_pc_load <= 1'b0;
         r_flush   <= 1'b0;
         r_retire  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_regs    <= w_regs_nxt;
         r_pc      <= w_pc_nxt;
         r_pc_load <= w_pc_load_nxt;
         r_flush   <= w_flush_nxt;
         r_retire  <= w_retire_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:   if (w_xfer && w_jmp) w_state_nxt = S_FLUSH;
         S_FLUSH: if (r_cnt == CNT_W'(1)) w_state_nxt = S_RUN;
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Next values for the registered outputs; squashed results touch nothing
   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_regs_nxt    = r_regs;
      w_pc_nxt      = r_pc;
      w_pc_load_nxt = 1'b0;
      w_retire_nxt  = r_retire;
      case (r_state)
         S_RUN: begin
            if (w_xfer) begin
               w_retire_nxt = r_retire + XLEN'(1);
               if (w_jmp) begin
                  w_pc_nxt      = outval;
                  w_pc_load_nxt = 1'b1;
                  w_cnt_nxt     = CNT_W'(FLUSH_CYCLES);
               end else begin
                  w_pc_nxt = r_pc + XLEN'(PC_STEP);
                  if (w_wr_en) w_regs_nxt[outreg[3:0]] = outval;
               end
            end
         end
         S_FLUSH: w_cnt_nxt = r_cnt - CNT_W'(1);
         default: w_cnt_nxt = '0;
      endcase
      w_flush_nxt = (w_state_nxt == S_FLUSH);
   end

   assign regarray     = r_regs;
   assign pc           = r_pc;
   assign pc_load      = r_pc_load;
   assign flush        = r_flush;
   assign retire_count = r_retire;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model of the stage.
module tb_writeback_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FLUSH_N  = 2;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       outval;
   logic [5:0]        outreg;
   logic [15:0][31:0] regarray;
   logic [31:0]       pc;
   logic              pc_load;
   logic              flush;
   logic [31:0]       retire_count;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_regs [16];
   logic [31:0] m_pc;
   logic [31:0] m_retire;
   logic        m_pc_load;
   int          m_squash_left;

   writeback_unit #(
      .RESET_PC(RESET_PC), .PC_STEP(4), .FLUSH_CYCLES(FLUSH_N), .R0_ZERO(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .outval(outval), .outreg(outreg), .regarray(regarray), .pc(pc),
      .pc_load(pc_load), .flush(flush), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the stage, described per result rather than per state
   task automatic model_step(input logic rst, input logic v, input logic [31:0] val, input logic [5:0] rg);
      if (!rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_pc = RESET_PC; m_retire = 32'h0; m_pc_load = 1'b0; m_squash_left = 0;
      end else if (m_squash_left > 0) begin
         m_squash_left--;
         m_pc_load = 1'b0;
      end else if (v) begin
         m_retire = m_retire + 32'd1;
         if (rg[5]) begin
            m_pc = val; m_pc_load = 1'b1; m_squash_left = FLUSH_N;
         end else begin
            m_pc_load = 1'b0;
            m_pc = m_pc + 32'd4;
            if (!rg[4] && rg[3:0] != 4'd0) m_regs[rg[3:0]] = val;
         end
      end else begin
         m_pc_load = 1'b0;
      end
   endtask

   task automatic compare_all();
      check_eq("pc", pc, m_pc);
      check_eq("pc_load", 32'(pc_load), 32'(m_pc_load));
      check_eq("flush", 32'(flush), 32'(m_squash_left > 0));
      check_eq("retire_count", retire_count, m_retire);
      check_eq("in_ready", 32'(in_ready), 32'(rst_n));
      for (int i = 0; i < 16; i++) check_eq($sformatf("r%0d", i), regarray[i], m_regs[i]);
   endtask

   task automatic cyc(input logic rst, input logic v, input logic [31:0] val, input logic [5:0] rg);
      @(negedge clk);
      rst_n = rst; in_valid = v; outval = val; outreg = rg;
      @(posedge clk);
      model_step(rst, v, val, rg);
      #1;
      compare_all();
   endtask

   initial begin
      logic [31:0] r_tmp;
      logic [5:0]  rg;
      rst_n = 1'b0; in_valid = 1'b0; outval = 32'h0; outreg = 6'h0;
      foreach (m_regs[i]) m_regs[i] = 32'hX;
      m_pc = 32'hX; m_retire = 32'hX; m_pc_load = 1'b0; m_squash_left = 0;

      cyc(1'b0, 1'b0, 32'h0, 6'h0);
      cyc(1'b0, 1'b1, 32'h5555_5555, 6'h03);
      check_eq("reset_pc", pc, RESET_PC);
      check_eq("reset_in_ready", 32'(in_ready), 32'd0);

      // Basic write
      cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 6'h05);
      check_eq("wr_r5", regarray[5], 32'hDEAD_BEEF);
      check_eq("wr_pc", pc, RESET_PC + 32'd4);
      check_eq("wr_retire", retire_count, 32'd1);

      // Register 0 is read-only
      cyc(1'b1, 1'b1, 32'h0000_1234, 6'h00);
      check_eq("r0_zero", regarray[0], 32'h0);
      check_eq("r0_pc", pc, RESET_PC + 32'd8);
      check_eq("r0_retire", retire_count, 32'd2);

      // Sink result retires without writing
      cyc(1'b1, 1'b1, 32'h7, 6'h17);
      check_eq("sink_r7", regarray[7], 32'h0);
      check_eq("sink_retire", retire_count, 32'd3);

      // Jump then three writes: first two squashed
      cyc(1'b1, 1'b1, 32'h100, 6'h20);
      check_eq("jmp_pc", pc, 32'h100);
      check_eq("jmp_pc_load", 32'(pc_load), 32'd1);
      check_eq("jmp_flush", 32'(flush), 32'd1);
      cyc(1'b1, 1'b1, 32'h1111, 6'h01);
      check_eq("sq_pc_load", 32'(pc_load), 32'd0);
      check_eq("sq_r1", regarray[1], 32'h0);
      cyc(1'b1, 1'b1, 32'h2222, 6'h02);
      check_eq("sq_r2", regarray[2], 32'h0);
      check_eq("sq_end_flush", 32'(flush), 32'd0);
      cyc(1'b1, 1'b1, 32'h3333, 6'h03);
      check_eq("post_r3", regarray[3], 32'h3333);
      check_eq("post_pc", pc, 32'h104);
      check_eq("post_retire", retire_count, 32'd5);

      // Reset during flush abandons the write
      cyc(1'b1, 1'b1, 32'h200, 6'h2A);
      cyc(1'b0, 1'b1, 32'h4444, 6'h04);
      check_eq("rstfl_r4", regarray[4], 32'h0);
      check_eq("rstfl_r5", regarray[5], 32'h0);
      check_eq("rstfl_pc", pc, RESET_PC);
      check_eq("rstfl_flush", 32'(flush), 32'd0);
      cyc(1'b1, 1'b1, 32'h4444, 6'h04);
      check_eq("rel_r4", regarray[4], 32'h4444);

      // PC wraps modulo 2^32
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 6'h20);
      cyc(1'b1, 1'b0, 32'h0, 6'h00);
      cyc(1'b1, 1'b0, 32'h0, 6'h00);
      cyc(1'b1, 1'b1, 32'h7777, 6'h07);
      check_eq("wrap_pc", pc, 32'h0);
      check_eq("wrap_r7", regarray[7], 32'h7777);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r_tmp = $urandom;
         rg = 6'($urandom);
         rg[5] = ($urandom_range(0, 9) == 0);
         cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), r_tmp, rg);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
